// File: rtl/b13_serial_rx.sv
// rtl/b13_serial_rx.sv - b13 serial link receiver; optional parity bit via B13_RX_PARITY_EN
module b13_serial_rx #(
    parameter int BIT_TICKS = 104,
    parameter int CNT_W     = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       SERIAL_IN,
    input  logic       RX_ACK,
    input  logic       ERR_CLR,
    output logic       DSR,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_BUSY,
    output logic       FRAME_ERROR,
    output logic       OVERRUN,
    output logic       PARITY_ERROR
);

`ifdef B13_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_t;
`endif

    // Counter values seen on the edge that takes a sample.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_TICKS - 1);

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             dsr_q, dsr_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             deliver;
    logic             set_frame;
    logic             set_overrun;
    logic             s;

    assign s = sync2_q;

`ifdef B13_RX_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic set_parity;
`endif

    // Line synchroniser plus all state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            dsr_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= SERIAL_IN;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            dsr_q       <= dsr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef B13_RX_PARITY_EN
    // Sticky parity flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
`endif

    // Frame FSM: samples mid-bit, shifts data LSB first, checks stop bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        set_frame = 1'b0;
`ifdef B13_RX_PARITY_EN
        set_parity = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef B13_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef B13_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d      = '0;
                    set_parity = (s != ^shift_q);
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (s) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        set_frame = 1'b1;
                        state_d   = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Host buffer handshake, DSR and sticky flags; a set beats a clear.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        set_overrun = 1'b0;
        if (deliver) begin
            if (!valid_q || RX_ACK) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                set_overrun = 1'b1;
            end
        end else if (RX_ACK) begin
            valid_d = 1'b0;
        end
        dsr_d       = ~valid_q;
        frame_err_d = set_frame | (frame_err_q & ~ERR_CLR);
        overrun_d   = set_overrun | (overrun_q & ~ERR_CLR);
`ifdef B13_RX_PARITY_EN
        parity_err_d = set_parity | (parity_err_q & ~ERR_CLR);
`endif
    end

    assign DSR         = dsr_q;
    assign RX_DATA     = data_q;
    assign RX_VALID    = valid_q;
    assign RX_BUSY     = (state_q != S_IDLE);
    assign FRAME_ERROR = frame_err_q;
    assign OVERRUN     = overrun_q;
`ifdef B13_RX_PARITY_EN
    assign PARITY_ERROR = parity_err_q;
`else
    assign PARITY_ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_b13_serial_rx.sv
// tb/tb_b13_serial_rx.sv - self-checking bench for b13_serial_rx
module tb_b13_serial_rx;

    localparam int B = 8;
`ifdef B13_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int DELIV = 2 + B / 2 + (NB - 1) * B;

    logic       clock;
    logic       reset;
    logic       SERIAL_IN;
    logic       RX_ACK;
    logic       ERR_CLR;
    logic       DSR;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_BUSY;
    logic       FRAME_ERROR;
    logic       OVERRUN;
    logic       PARITY_ERROR;

    int n_run;
    int n_fail;
    logic obs_valid [0:511];
    logic obs_dsr   [0:511];
    logic [7:0] last_byte;

    b13_serial_rx #(.BIT_TICKS(B), .CNT_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .SERIAL_IN   (SERIAL_IN),
        .RX_ACK      (RX_ACK),
        .ERR_CLR     (ERR_CLR),
        .DSR         (DSR),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .RX_BUSY     (RX_BUSY),
        .FRAME_ERROR (FRAME_ERROR),
        .OVERRUN     (OVERRUN),
        .PARITY_ERROR(PARITY_ERROR)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Plays one frame; iteration c drives the level seen by rising edge c
    // (edge 0 = start bit falls) and records outputs into index c+1.
    task automatic play_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int extra, input logic after_lvl,
                              input int ack_cycle, input int abort_at);
        int total;
        int idx;
        logic lv;
        total = NB * B + extra;
        for (int c = 0; c < total; c++) begin
            if (c == abort_at) return;
            idx = c / B;
            if (idx == 0) lv = 1'b0;
            else if (idx <= 8) lv = data[idx-1];
            else if (NB == 11 && idx == 9) lv = par;
            else if (idx == NB - 1) lv = stop;
            else lv = after_lvl;
            SERIAL_IN = lv;
            RX_ACK    = (c == ack_cycle);
            ERR_CLR   = 1'b0;
            @(negedge clock);
            obs_valid[c+1] = RX_VALID;
            obs_dsr[c+1]   = DSR;
        end
        RX_ACK = 1'b0;
    endtask

    task automatic pulse(input logic ack, input logic clr);
        RX_ACK  = ack;
        ERR_CLR = clr;
        @(negedge clock);
        RX_ACK  = 1'b0;
        ERR_CLR = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; SERIAL_IN = 1'b1; RX_ACK = 1'b0; ERR_CLR = 1'b0;
        repeat (3) @(negedge clock);
        n_run++;
        if ({DSR, RX_DATA, RX_VALID, RX_BUSY, FRAME_ERROR, OVERRUN, PARITY_ERROR} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b%h%b%b%b%b%b want all zero", DSR, RX_DATA,
                     RX_VALID, RX_BUSY, FRAME_ERROR, OVERRUN, PARITY_ERROR);
        end
        reset = 1'b0;
        @(negedge clock);
        n_run++;
        if (DSR !== 1'b1 || RX_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: DSR=%b RX_VALID=%b want DSR=1 RX_VALID=0", DSR, RX_VALID);
        end
    endtask

    task automatic test_single_frame;
        play_frame(8'hA5, 1'b0, 1'b1, 4, 1'b1, -1, -1);
        n_run++;
        if (obs_valid[DELIV] !== 1'b0 || obs_valid[DELIV+1] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_valid_timing: cyc%0d=%b cyc%0d=%b want 0 then 1",
                     DELIV, obs_valid[DELIV], DELIV + 1, obs_valid[DELIV+1]);
        end
        n_run++;
        if (obs_dsr[DELIV+1] !== 1'b1 || obs_dsr[DELIV+2] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_dsr_timing: cyc%0d=%b cyc%0d=%b want 1 then 0",
                     DELIV + 1, obs_dsr[DELIV+1], DELIV + 2, obs_dsr[DELIV+2]);
        end
        n_run++;
        if (RX_DATA !== 8'hA5 || {FRAME_ERROR, OVERRUN, PARITY_ERROR} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_data: data=%h flags=%b%b%b want a5 000", RX_DATA,
                     FRAME_ERROR, OVERRUN, PARITY_ERROR);
        end
    endtask

    task automatic test_overrun;
        play_frame(8'h3C, 1'b0, 1'b1, 4, 1'b1, -1, -1);
        n_run++;
        if (RX_DATA !== 8'hA5 || OVERRUN !== 1'b1 || RX_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: data=%h ovr=%b valid=%b want a5 1 1", RX_DATA, OVERRUN, RX_VALID);
        end
        pulse(1'b1, 1'b0);
        n_run++;
        if (RX_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_clears_valid: valid=%b want 0", RX_VALID);
        end
        @(negedge clock);
        n_run++;
        if (DSR !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_dsr: DSR=%b want 1", DSR);
        end
        pulse(1'b0, 1'b1);
        n_run++;
        if (OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr_overrun: ovr=%b want 0", OVERRUN);
        end
    endtask

    task automatic test_glitch;
        logic saw_busy;
        saw_busy = 1'b0;
        SERIAL_IN = 1'b0;
        repeat (2) @(negedge clock);
        SERIAL_IN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (RX_BUSY === 1'b1) saw_busy = 1'b1;
        end
        n_run++;
        if (saw_busy !== 1'b1 || RX_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: saw_busy=%b busy_now=%b want 1 0", saw_busy, RX_BUSY);
        end
        n_run++;
        if ({RX_VALID, FRAME_ERROR, OVERRUN, PARITY_ERROR} !== 4'b0000) begin
            n_fail++;
            $display("FAIL glitch_quiet: valid/flags=%b%b%b%b want 0000", RX_VALID,
                     FRAME_ERROR, OVERRUN, PARITY_ERROR);
        end
    endtask

    task automatic test_frame_error;
        logic any_valid;
        play_frame(8'h00, 1'b0, 1'b0, 40, 1'b0, -1, -1);
        any_valid = 1'b0;
        for (int i = 1; i <= NB * B + 40; i++) if (obs_valid[i] !== 1'b0) any_valid = 1'b1;
        n_run++;
        if (any_valid !== 1'b0 || FRAME_ERROR !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_error: delivered=%b ferr=%b want 0 1", any_valid, FRAME_ERROR);
        end
        n_run++;
        if (RX_BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL break_busy: busy=%b want 1", RX_BUSY);
        end
        SERIAL_IN = 1'b1;
        repeat (6) @(negedge clock);
        n_run++;
        if (RX_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL break_release: busy=%b want 0", RX_BUSY);
        end
        play_frame(8'h81, 1'b0, 1'b1, 4, 1'b1, -1, -1);
        n_run++;
        if (RX_DATA !== 8'h81 || RX_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL after_break_frame: data=%h valid=%b want 81 1", RX_DATA, RX_VALID);
        end
    endtask

    task automatic test_reset_midframe;
        play_frame(8'hC3, 1'b0, 1'b1, 4, 1'b1, -1, 30);
        reset = 1'b1;
        #1;
        n_run++;
        if ({DSR, RX_DATA, RX_VALID, RX_BUSY, FRAME_ERROR, OVERRUN, PARITY_ERROR} !== 14'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got %b%h%b%b%b%b%b want all zero", DSR, RX_DATA,
                     RX_VALID, RX_BUSY, FRAME_ERROR, OVERRUN, PARITY_ERROR);
        end
        repeat (2) @(negedge clock);
        SERIAL_IN = 1'b1;
        reset = 1'b0;
        repeat (4) @(negedge clock);
        play_frame(8'h5A, 1'b0, 1'b1, 4, 1'b1, -1, -1);
        n_run++;
        if (RX_DATA !== 8'h5A || RX_VALID !== 1'b1 || {FRAME_ERROR, OVERRUN, PARITY_ERROR} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_frame: data=%h valid=%b flags=%b%b%b want 5a 1 000",
                     RX_DATA, RX_VALID, FRAME_ERROR, OVERRUN, PARITY_ERROR);
        end
        pulse(1'b1, 1'b1);
    endtask

`ifdef B13_RX_PARITY_EN
    task automatic test_parity;
        play_frame(8'h07, 1'b0, 1'b1, 4, 1'b1, -1, -1);
        n_run++;
        if (PARITY_ERROR !== 1'b1 || RX_DATA !== 8'h07 || obs_valid[87] !== 1'b1 || obs_valid[86] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bad: perr=%b data=%h v86=%b v87=%b want 1 07 0 1",
                     PARITY_ERROR, RX_DATA, obs_valid[86], obs_valid[87]);
        end
        pulse(1'b1, 1'b1);
        play_frame(8'h07, 1'b1, 1'b1, 4, 1'b1, -1, -1);
        n_run++;
        if (PARITY_ERROR !== 1'b0 || RX_DATA !== 8'h07 || RX_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_good: perr=%b data=%h valid=%b want 0 07 1",
                     PARITY_ERROR, RX_DATA, RX_VALID);
        end
        pulse(1'b1, 1'b1);
    endtask
`endif

    task automatic test_back_to_back;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = 8'($urandom);
        play_frame(a, ^a, 1'b1, 0, 1'b1, -1, -1);
        play_frame(b, ^b, 1'b1, 4, 1'b1, DELIV, -1);
        n_run++;
        if (obs_valid[DELIV] !== 1'b1 || obs_valid[DELIV+1] !== 1'b1 || obs_valid[DELIV+2] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_valid_held: %b%b%b want 111", obs_valid[DELIV],
                     obs_valid[DELIV+1], obs_valid[DELIV+2]);
        end
        n_run++;
        if (RX_DATA !== b || OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_data: data=%h ovr=%b want %h 0", RX_DATA, OVERRUN, b);
        end
        last_byte = b;
    endtask

    // Reference model: one-deep buffer and sticky flags tracked per frame.
    task automatic test_random;
        logic       m_valid, m_ferr, m_ovr, m_perr;
        logic [7:0] m_data;
        logic [7:0] d;
        logic       stop, pw, a, c;
        pulse(1'b1, 1'b1);
        m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        m_data  = last_byte;
        for (int f = 0; f < 20; f++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            pw   = (NB == 11) && ($urandom_range(0, 3) == 0);
            play_frame(d, (^d) ^ pw, stop, 6, 1'b1, -1, -1);
            if (pw) m_perr = 1'b1;
            if (!stop) m_ferr = 1'b1;
            else if (m_valid) m_ovr = 1'b1;
            else begin
                m_valid = 1'b1;
                m_data  = d;
            end
            n_run++;
            if ({RX_VALID, RX_DATA, FRAME_ERROR, OVERRUN, PARITY_ERROR} !==
                {m_valid, m_data, m_ferr, m_ovr, m_perr}) begin
                n_fail++;
                $display("FAIL rand_frame%0d: v=%b d=%h f=%b o=%b p=%b want v=%b d=%h f=%b o=%b p=%b",
                         f, RX_VALID, RX_DATA, FRAME_ERROR, OVERRUN, PARITY_ERROR,
                         m_valid, m_data, m_ferr, m_ovr, m_perr);
            end
            a = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 3) == 0);
            pulse(a, c);
            if (a) m_valid = 1'b0;
            if (c) begin
                m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            end
            n_run++;
            if ({RX_VALID, FRAME_ERROR, OVERRUN, PARITY_ERROR} !== {m_valid, m_ferr, m_ovr, m_perr}) begin
                n_fail++;
                $display("FAIL rand_host%0d: v=%b f=%b o=%b p=%b want %b %b %b %b", f, RX_VALID,
                         FRAME_ERROR, OVERRUN, PARITY_ERROR, m_valid, m_ferr, m_ovr, m_perr);
            end
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        last_byte = 8'h00;
        test_reset;
        test_single_frame;
        test_overrun;
        test_glitch;
        test_frame_error;
        test_reset_midframe;
`ifdef B13_RX_PARITY_EN
        test_parity;
`endif
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
